// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch buffer: FSM states, queued entry layout,
// the default boot PC and a small alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DROP     = 2'd2
  } fetch_state_e;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;

  function automatic logic misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; head output reads as zero while empty.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: one outstanding imem read per PC, results queued for decode.
// Optional misaligned-PC fault entries are enabled by FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_i,
  input  logic         redirect_i,
  output logic         pc_hold_o,
  output logic         imem_req_valid_o,
  input  logic         imem_req_ready_i,
  output logic [N-1:0] imem_req_addr_o,
  input  logic         imem_rsp_valid_i,
  input  logic [N-1:0] imem_rsp_data_i,
  output logic         dec_valid_o,
  input  logic         dec_ready_i,
  output logic [N-1:0] dec_instr_o,
  output logic [N-1:0] dec_pc_o,
  output logic         dec_fault_o
);

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam int EW = 2 * N + 1;
`else
  localparam int EW = 2 * N;
`endif

  fetch_state_e   state_q, state_d;
  logic [N-1:0]   req_pc_q;
  logic           fifo_full;
  logic           fifo_empty;
  logic           req_fire;
  logic           rsp_push;
  logic           fault_push;
  logic           fetch_block;
  logic           push;
  logic [EW-1:0]  push_data;
  logic [EW-1:0]  head_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic stall_q;

  // A misaligned PC produces one fault entry, then fetch stays parked until a redirect.
  assign fault_push  = (state_q == IDLE) && !redirect_i && !fifo_full && !stall_q &&
                       misaligned(pc_i[1:0]);
  assign fetch_block = stall_q || misaligned(pc_i[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          stall_q <= 1'b0;
    else if (redirect_i) stall_q <= 1'b0;
    else if (fault_push) stall_q <= 1'b1;
  end

  assign push_data = fault_push ? {{N{1'b0}}, pc_i, 1'b1}
                                : {imem_rsp_data_i, req_pc_q, 1'b0};
  assign {dec_instr_o, dec_pc_o, dec_fault_o} = head_data;
`else
  assign fault_push  = 1'b0;
  assign fetch_block = 1'b0;
  assign push_data   = {imem_rsp_data_i, req_pc_q};
  assign {dec_instr_o, dec_pc_o} = head_data;
  assign dec_fault_o = 1'b0;
`endif

  // The count<DEPTH gate reserves a slot for the response before the request leaves.
  assign imem_req_valid_o = (state_q == IDLE) && !redirect_i && !fifo_full && !fetch_block;
  assign imem_req_addr_o  = pc_i;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign pc_hold_o        = !req_fire;

  assign rsp_push    = (state_q == WAIT_RSP) && imem_rsp_valid_i && !redirect_i;
  assign push        = rsp_push || fault_push;
  assign dec_valid_o = !fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (imem_rsp_valid_i) state_d = IDLE;
        else if (redirect_i)  state_d = DROP;
      end
      DROP: begin
        if (imem_rsp_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) req_pc_q <= pc_i;
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_data),
    .pop       (dec_valid_o && dec_ready_i),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Bench for instruction_fetch_buffer: latency-programmable memory model plus
// an in-order scoreboard of expected decode entries.
module tb_instruction_fetch_buffer;
  import fetch_pkg::*;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] pc_i;
  logic         redirect_i;
  logic         pc_hold_o;
  logic         imem_req_valid_o;
  logic         imem_req_ready_i;
  logic [N-1:0] imem_req_addr_o;
  logic         imem_rsp_valid_i = 1'b0;
  logic [N-1:0] imem_rsp_data_i  = '0;
  logic         dec_valid_o;
  logic         dec_ready_i;
  logic [N-1:0] dec_instr_o;
  logic [N-1:0] dec_pc_o;
  logic         dec_fault_o;

  instruction_fetch_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_i             (pc_i),
    .redirect_i       (redirect_i),
    .pc_hold_o        (pc_hold_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .dec_valid_o      (dec_valid_o),
    .dec_ready_i      (dec_ready_i),
    .dec_instr_o      (dec_instr_o),
    .dec_pc_o         (dec_pc_o),
    .dec_fault_o      (dec_fault_o)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  fetch_entry_t exp_q[$];
  logic [31:0]  acc_q[$];
  int           lat = 1;
  int           rem = 0;
  bit           pending = 1'b0;
  bit           stale = 1'b0;
  logic [31:0]  pend_addr = '0;
  int           cycle = 0;
  int           pop_cnt = 0;
  int           last_pop_cycle = 0;
  int           last_pop_gap = 0;
  logic         hold_s = 1'b1;
  logic         redir_s = 1'b0;
  logic [31:0]  redir_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Mid-cycle: scoreboard pop check, then memory model, then PC-logic samples.
  always @(negedge clk) begin
    fetch_entry_t e;
    cycle++;
    hold_s  = pc_hold_o;
    redir_s = redirect_i;
    if (!reset) begin
      pending = 1'b0;
      stale = 1'b0;
      imem_rsp_valid_i = 1'b0;
      exp_q.delete();
    end else begin
      if (dec_valid_o && dec_ready_i && !redirect_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got pc=%h instr=%h, want no entry", dec_pc_o, dec_instr_o);
        end else begin
          e = exp_q.pop_front();
          if (dec_instr_o !== e.instr || dec_pc_o !== e.pc || dec_fault_o !== e.fault) begin
            n_fail++;
            $display("FAIL dec_entry: got instr=%h pc=%h fault=%b, want instr=%h pc=%h fault=%b",
                     dec_instr_o, dec_pc_o, dec_fault_o, e.instr, e.pc, e.fault);
          end
        end
        pop_cnt++;
        last_pop_gap = cycle - last_pop_cycle;
        last_pop_cycle = cycle;
      end
      if (redirect_i) exp_q.delete();
      imem_rsp_valid_i = 1'b0;
      if (pending) begin
        if (redirect_i) stale = 1'b1;
        rem--;
        if (rem == 0) begin
          pending = 1'b0;
          imem_rsp_valid_i = 1'b1;
          imem_rsp_data_i = mem_word(pend_addr);
          if (!stale) begin
            e.instr = mem_word(pend_addr);
            e.pc = pend_addr;
            e.fault = 1'b0;
            exp_q.push_back(e);
          end
        end
      end
      if (imem_req_valid_o && imem_req_ready_i) begin
        pending = 1'b1;
        stale = 1'b0;
        rem = lat;
        pend_addr = imem_req_addr_o;
        acc_q.push_back(imem_req_addr_o);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (redir_s)      pc_i = redir_target;
      else if (!hold_s) pc_i = pc_i + 32'd4;
    end
  endtask

  task automatic quiesce();
    bit done = 1'b0;
    imem_req_ready_i = 1'b0;
    dec_ready_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1);
      if (!pending && !dec_valid_o) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL quiesce_timeout: got pending=%b dec_valid=%b, want both 0", pending, dec_valid_o);
    end
    acc_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pc_i = RESET_PC;
    redirect_i = 1'b0;
    imem_req_ready_i = 1'b0;
    dec_ready_i = 1'b0;
    lat = 1;
    step(3);
    n_checks++;
    if (dec_valid_o !== 1'b0 || dec_instr_o !== '0 || dec_pc_o !== '0 || dec_fault_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dec: got valid=%b instr=%h pc=%h fault=%b, want all 0",
               dec_valid_o, dec_instr_o, dec_pc_o, dec_fault_o);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_release_req: got valid=%b addr=%h, want 1 %h",
               imem_req_valid_o, imem_req_addr_o, RESET_PC);
    end
    n_checks++;
    if (pc_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold: got %b, want 1", pc_hold_o);
    end
  endtask

  task automatic test_stream();
    int p0 = pop_cnt;
    bit done = 1'b0;
    acc_q.delete();
    lat = 1;
    imem_req_ready_i = 1'b1;
    dec_ready_i = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      step(1);
      if (pop_cnt - p0 >= 6) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d pops, want 6", pop_cnt - p0);
    end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      n_checks++;
      if (acc_q[i] !== RESET_PC + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL stream_addr%0d: got %h, want %h", i, acc_q[i], RESET_PC + 32'(4 * i));
      end
    end
    n_checks++;
    if (last_pop_gap != 2) begin
      n_fail++;
      $display("FAIL stream_rate: got gap %0d cycles, want 2", last_pop_gap);
    end
    quiesce();
  endtask

  task automatic test_backpressure();
    int p0;
    lat = 1;
    pc_i = RESET_PC + 32'h40;
    dec_ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    step(8);
    n_checks++;
    if (acc_q.size() != 2) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d, want 2", acc_q.size());
    end
    n_checks++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== RESET_PC + 32'h40) begin
      n_fail++;
      $display("FAIL bp_head: got valid=%b pc=%h, want 1 %h", dec_valid_o, dec_pc_o, RESET_PC + 32'h40);
    end
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || pc_hold_o !== 1'b1 || imem_req_addr_o !== RESET_PC + 32'h48) begin
      n_fail++;
      $display("FAIL bp_withheld: got req_valid=%b hold=%b addr=%h, want 0 1 %h",
               imem_req_valid_o, pc_hold_o, imem_req_addr_o, RESET_PC + 32'h48);
    end
    p0 = pop_cnt;
    imem_req_ready_i = 1'b0;
    dec_ready_i = 1'b1;
    step(3);
    n_checks++;
    if (pop_cnt - p0 != 2 || dec_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got pops=%0d valid=%b, want 2 0", pop_cnt - p0, dec_valid_o);
    end
    quiesce();
  endtask

  task automatic test_req_stall();
    pc_i = RESET_PC + 32'h80;
    dec_ready_i = 1'b1;
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++;
      if (pc_hold_o !== 1'b1 || imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RESET_PC + 32'h80) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got hold=%b valid=%b addr=%h, want 1 1 %h",
                 i, pc_hold_o, imem_req_valid_o, imem_req_addr_o, RESET_PC + 32'h80);
      end
    end
    imem_req_ready_i = 1'b1;
    step(1);
    imem_req_ready_i = 1'b0;
    #1;
    n_checks++;
    if (acc_q.size() != 1 || pc_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got accepts=%0d hold=%b, want 1 1", acc_q.size(), pc_hold_o);
    end else if (acc_q[0] !== RESET_PC + 32'h80) begin
      n_fail++;
      $display("FAIL stall_release_addr: got %h, want %h", acc_q[0], RESET_PC + 32'h80);
    end
    quiesce();
  endtask

  task automatic test_redirect_drop();
    lat = 3;
    pc_i = RESET_PC + 32'h100;
    dec_ready_i = 1'b1;
    imem_req_ready_i = 1'b1;
    step(1);
    n_checks++;
    if (acc_q.size() != 1) begin
      n_fail++;
      $display("FAIL drop_accept: got %0d, want 1", acc_q.size());
    end
    redir_target = 32'h0050_0000;
    redirect_i = 1'b1;
    step(1);
    redirect_i = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || pc_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_state1: got req_valid=%b hold=%b, want 0 1", imem_req_valid_o, pc_hold_o);
    end
    step(1);
    n_checks++;
    if (imem_req_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_state2: got req_valid=%b, want 0", imem_req_valid_o);
    end
    step(1);
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || dec_valid_o !== 1'b0 || imem_req_addr_o !== 32'h0050_0000) begin
      n_fail++;
      $display("FAIL drop_done: got req_valid=%b dec_valid=%b addr=%h, want 1 0 00500000",
               imem_req_valid_o, dec_valid_o, imem_req_addr_o);
    end
    step(1);
    n_checks++;
    if (acc_q.size() != 2) begin
      n_fail++;
      $display("FAIL drop_next_req: got %0d accepts, want 2", acc_q.size());
    end else if (acc_q[1] !== 32'h0050_0000) begin
      n_fail++;
      $display("FAIL drop_next_addr: got %h, want 00500000", acc_q[1]);
    end
    quiesce();
  endtask

  task automatic test_redirect_flush();
    int  p0;
    bit  hit = 1'b0;
    lat = 2;
    pc_i = RESET_PC + 32'h200;
    dec_ready_i = 1'b0;
    imem_req_ready_i = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1);
      if (pending && rem == 1 && dec_valid_o) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL flush_rsp_setup: got no response window, want one");
    end
    p0 = pop_cnt;
    redir_target = RESET_PC + 32'h300;
    redirect_i = 1'b1;
    dec_ready_i = 1'b1;
    step(1);
    redirect_i = 1'b0;
    dec_ready_i = 1'b0;
    #1;
    n_checks++;
    if (dec_valid_o !== 1'b0 || pop_cnt != p0 || imem_req_valid_o !== 1'b1 ||
        imem_req_addr_o !== RESET_PC + 32'h300) begin
      n_fail++;
      $display("FAIL flush_rsp: got dec_valid=%b pops=%0d req_valid=%b addr=%h, want 0 0 1 %h",
               dec_valid_o, pop_cnt - p0, imem_req_valid_o, imem_req_addr_o, RESET_PC + 32'h300);
    end
    lat = 1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1);
      if (!pending && !imem_req_valid_o && dec_valid_o) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL flush_full_setup: got no full FIFO, want full");
    end
    p0 = pop_cnt;
    redir_target = RESET_PC + 32'h400;
    redirect_i = 1'b1;
    dec_ready_i = 1'b1;
    step(1);
    redirect_i = 1'b0;
    #1;
    n_checks++;
    if (dec_valid_o !== 1'b0 || pop_cnt != p0 || imem_req_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: got dec_valid=%b pops=%0d req_valid=%b, want 0 0 1",
               dec_valid_o, pop_cnt - p0, imem_req_valid_o);
    end
    quiesce();
  endtask

  task automatic test_misalign();
    fetch_entry_t e;
    int p0;
    lat = 1;
    pc_i = 32'h0040_0002;
    dec_ready_i = 1'b1;
    imem_req_ready_i = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    e.instr = '0;
    e.pc = 32'h0040_0002;
    e.fault = 1'b1;
    exp_q.push_back(e);
    #1;
    n_checks++;
    if (imem_req_valid_o !== 1'b0 || pc_hold_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_noreq: got req_valid=%b hold=%b, want 0 1", imem_req_valid_o, pc_hold_o);
    end
    p0 = pop_cnt;
    step(1);
    n_checks++;
    if (dec_valid_o !== 1'b1 || dec_fault_o !== 1'b1 || dec_pc_o !== 32'h0040_0002 || dec_instr_o !== '0) begin
      n_fail++;
      $display("FAIL mis_entry: got valid=%b fault=%b pc=%h instr=%h, want 1 1 00400002 0",
               dec_valid_o, dec_fault_o, dec_pc_o, dec_instr_o);
    end
    step(5);
    n_checks++;
    if (acc_q.size() != 0 || pop_cnt - p0 != 1 || imem_req_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_stall: got accepts=%0d pops=%0d req_valid=%b, want 0 1 0",
               acc_q.size(), pop_cnt - p0, imem_req_valid_o);
    end
    redir_target = RESET_PC + 32'h500;
    redirect_i = 1'b1;
    step(1);
    redirect_i = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RESET_PC + 32'h500) begin
      n_fail++;
      $display("FAIL mis_resume: got req_valid=%b addr=%h, want 1 %h",
               imem_req_valid_o, imem_req_addr_o, RESET_PC + 32'h500);
    end
`else
    e = '0;
    p0 = pop_cnt;
    #1;
    n_checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0040_0002) begin
      n_fail++;
      $display("FAIL mis_passthru: got req_valid=%b addr=%h, want 1 00400002 (pops %0d, %b)",
               imem_req_valid_o, imem_req_addr_o, p0, e.fault);
    end
    step(1);
    n_checks++;
    if (acc_q.size() != 1) begin
      n_fail++;
      $display("FAIL mis_passthru_accept: got %0d, want 1", acc_q.size());
    end
`endif
    quiesce();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_drop();
    test_redirect_flush();
    test_misalign();
    #1;
    n_checks++;
    if (exp_q.size() != 0 || dec_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL final_empty: got pending entries=%0d dec_valid=%b, want 0 0", exp_q.size(), dec_valid_o);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_buffer.md
# instruction_fetch_buffer

Fetch stage directly downstream of the PC register. It takes the current PC value and issues one instruction-memory read per PC. It queues each returned instruction with its PC in a small FIFO and presents it to decode through a valid/ready handshake. It tells the next-PC logic when to hold the PC, and flushes all in-flight work on a control-flow redirect.

## Interface
Parameters:
- N, 32, address/data width
- DEPTH, 2, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pc_i  in  N  current PC from PC register
- redirect_i  in  1  branch/jump taken; flush everything this cycle
- pc_hold_o  out  1  next-PC mux must reload pc_i (ignored while redirect_i=1)
- imem_req_valid_o  out  1  read request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  N  read address (= pc_i)
- imem_rsp_valid_i  in  1  read data valid (one cycle pulse)
- imem_rsp_data_i  in  N  instruction word
- dec_valid_o  out  1  head entry valid
- dec_ready_i  in  1  decode consumes head
- dec_instr_o  out  N  head instruction
- dec_pc_o  out  N  head PC
- dec_fault_o  out  1  head entry is a misaligned-fetch fault (0 when macro absent)

## Operation
- FSM states:
  - IDLE: no outstanding request.
  - WAIT_RSP: one request outstanding, response kept.
  - DROP: one request outstanding, response discarded.
- At most one outstanding request; memory response latency ≥1 cycle, unbounded.
- imem_req_valid_o = (state==IDLE) && !redirect_i && (count < DEPTH).
- imem_req_addr_o = pc_i.
- Request accepted on valid && ready: latch pc_i into req_pc, go WAIT_RSP.
- pc_hold_o = !(imem_req_valid_o && imem_req_ready_i).
- In WAIT_RSP, imem_rsp_valid_i pushes {imem_rsp_data_i, req_pc, fault=0} into the FIFO and the FSM returns to IDLE.
- In DROP, imem_rsp_valid_i is discarded and the FSM returns to IDLE.
- Pop on dec_valid_o && dec_ready_i.
- dec_* outputs are driven from the FIFO head; dec_valid_o = (count != 0).
- Push and pop in the same cycle leave count unchanged. A push cannot occur while full, because the request gate reserves the slot.
- redirect_i:
  - Clears the FIFO (count=0, pointers reset) at the next edge; any same-cycle pop or push is void.
  - WAIT_RSP goes to DROP.
  - A same-cycle response in WAIT_RSP is discarded and the FSM goes to IDLE.
  - DROP stays DROP unless a response arrives, in which case it goes to IDLE.
  - IDLE stays IDLE; no request is issued that cycle.
- A response arriving in IDLE is a protocol error: it is ignored.

## Timing
- Reset (async assert, sync release): state=IDLE, count=0, pointers=0, req_pc=0.
- Output values during reset: imem_req_valid_o=1 once released if count<DEPTH; dec_valid_o=0; dec_instr_o=0, dec_pc_o=0, dec_fault_o=0.
- Reset mid-transaction abandons the outstanding request. The memory must also be reset by the same signal.
- Latency: request accepted at edge T, response at edge T+L, entry visible on dec_valid_o at T+L (registered FIFO, no bypass).
- Maximum throughput: one instruction per 2 cycles for L=1; the single-outstanding limit is intentional.
- pc_hold_o, imem_req_valid_o and imem_req_addr_o are combinational from state, count, redirect_i and pc_i.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - In IDLE with pc_i[1:0]≠0 and count<DEPTH, no memory request is issued.
  - Instead, {instr=0, pc=pc_i, fault=1} is pushed directly and pc_hold_o=1.
  - Further fetching stalls until redirect_i.
- FETCH_MISALIGN_CHECK_EN undefined:
  - pc_i[1:0] is ignored and the address is passed as-is.
  - dec_fault_o is tied to 0.

## Structure
- Shared package (fetch_pkg): fetch-state enum {IDLE, WAIT_RSP, DROP}, the entry struct {instr, pc, fault}, and RESET_PC = 32'h00400000 for benches.
- One sub-module: fetch_fifo (DEPTH-entry synchronous FIFO with flush, count, push/pop). The FSM and handshake glue live in the top module.

## Test plan
- Reset release with pc_i=0x00400000, ready=1, L=1, dec_ready=1 → requests at 0x00400000, 0x00400004, …; dec_pc_o sequence matches, one entry per 2 cycles.
- dec_ready_i=0 with 3 responses pending → count saturates at 2; third request withheld (imem_req_valid_o=0, pc_hold_o=1); releasing ready drains entries in order.
- imem_req_ready_i low for 5 cycles → pc_hold_o=1 throughout; pc_i stable; a single request is accepted when ready rises.
- redirect_i one cycle after request accept (L=3) → FSM enters DROP; the stale response is not enqueued; FIFO is empty; next request goes to the new pc_i.
- redirect_i coincident with response, and with a pop of a full FIFO → count=0 next cycle; dec_valid_o=0; no entry lost twice or duplicated.
- With FETCH_MISALIGN_CHECK_EN, pc_i=0x00400002 → no imem request; dec_fault_o=1 with dec_pc_o=0x00400002; the stall persists until redirect_i.
